// File: rtl/deserializer.sv
// Serial-to-parallel receiver: start bit, TXN_SZ data bits MSB first, even parity, stop bit (0).
// Recovered words sit in a one-entry valid/ready output register with parity/framing flags.
module deserializer #(
    parameter int TXN_SZ = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sin,
    output logic [TXN_SZ-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CW = $clog2(TXN_SZ + 2);
    localparam int SW = TXN_SZ + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(TXN_SZ + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HUNT
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [SW-1:0]   shreg;
    logic [TXN_SZ-1:0] frame_data;
    logic            frame_par;
    logic            complete;
    logic            load;

    function automatic logic parity_bad(input logic [TXN_SZ-1:0] d, input logic p);
        return (^d) != p;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        case (state)
            IDLE: if (sin) state_nxt = RECV;
            RECV: begin
                if (count == '0) begin
                    complete  = 1'b1;
                    state_nxt = sin ? HUNT : IDLE;
                end
            end
            HUNT: if (!sin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Shifter holds data + parity; the stop bit is taken live from sin on the completion cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
            shreg <= '0;
        end else if (state == IDLE && sin) begin
            count <= CNT_INIT;
        end else if (state == RECV) begin
            shreg <= {shreg[SW-2:0], sin};
            if (count != '0) count <= count - 1'b1;
        end
    end

    assign frame_data = shreg[SW-1:1];
    assign frame_par  = shreg[0];

    // A completing frame loads if the register is empty or being drained this same cycle.
    assign load = complete && (!dout_valid || dout_ready);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= complete && !load;
            if (load) begin
                dout       <= frame_data;
                parity_err <= parity_bad(frame_data, frame_par);
                frame_err  <= sin;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Randomized and directed bench for deserializer; frames are built at word level and
// the expected output register contents are tracked per clock from frame completions.
module tb_deserializer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       sin;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic       e_valid = 1'b0;
    logic [7:0] e_dout  = '0;
    logic       e_pe    = 1'b0;
    logic       e_fe    = 1'b0;
    logic       e_ovr   = 1'b0;

    deserializer #(.TXN_SZ(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive the line, advance the expected output register, compare.
    task automatic step(input logic s, input logic rdy, input logic comp,
                        input logic [7:0] w, input logic pe, input logic fe);
        sin        = s;
        dout_ready = rdy;
        @(posedge clock);
        e_ovr = 1'b0;
        if (!reset_n) begin
            e_valid = 1'b0; e_dout = '0; e_pe = 1'b0; e_fe = 1'b0;
        end else if (comp && (!e_valid || rdy)) begin
            e_valid = 1'b1; e_dout = w; e_pe = pe; e_fe = fe;
        end else if (comp) begin
            e_ovr = 1'b1;
        end else if (e_valid && rdy) begin
            e_valid = 1'b0;
        end
        #1;
        check("dout_valid", 32'(dout_valid), 32'(e_valid));
        check("overrun", 32'(overrun), 32'(e_ovr));
        if (e_valid) begin
            check("dout", 32'(dout), 32'(e_dout));
            check("parity_err", 32'(parity_err), 32'(e_pe));
            check("frame_err", 32'(frame_err), 32'(e_fe));
        end
    endtask

    function automatic logic pick_rdy(input int mode);
        if (mode == 2) return logic'($urandom_range(0, 1));
        return (mode == 1);
    endfunction

    // Full frame: start, data MSB first, parity (optionally inverted), stop.
    task automatic send_frame(input logic [7:0] d, input logic bad_par,
                              input logic stop, input int rmode);
        logic par;
        par = (^d) ^ bad_par;
        step(1'b1, pick_rdy(rmode), 1'b0, '0, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) step(d[i], pick_rdy(rmode), 1'b0, '0, 1'b0, 1'b0);
        step(par, pick_rdy(rmode), 1'b0, '0, 1'b0, 1'b0);
        step(stop, pick_rdy(rmode), 1'b1, d, bad_par, stop);
    endtask

    task automatic idle(input int n, input int rmode);
        for (int i = 0; i < n; i++) step(1'b0, pick_rdy(rmode), 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n    = 1'b0;
        sin        = 1'b0;
        dout_ready = 1'b0;
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pe", 32'(parity_err), 32'h0);
        check("rst_fe", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        idle(2, 1);

        // Good word, then a parity error word
        send_frame(8'hA5, 1'b0, 1'b0, 1);
        idle(3, 1);
        send_frame(8'h01, 1'b1, 1'b0, 0);
        idle(2, 0);
        idle(1, 1);

        // Stop bit high: line held high must stay in HUNT without new frames
        send_frame(8'h3C, 1'b0, 1'b1, 1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            check("hunt_busy", 32'(busy), 32'h1);
        end
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("hunt_exit", 32'(busy), 32'h0);
        idle(2, 1);

        // Zero-gap back-to-back frames
        send_frame(8'h11, 1'b0, 1'b0, 1);
        send_frame(8'h22, 1'b0, 1'b0, 1);
        send_frame(8'h33, 1'b0, 1'b0, 1);
        idle(3, 1);

        // Overrun: consumer stalled across two completions
        send_frame(8'h55, 1'b0, 1'b0, 0);
        send_frame(8'h66, 1'b0, 1'b0, 0);
        idle(3, 0);
        idle(2, 1);

        // Reset mid-frame aborts it
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        reset_n = 1'b0;
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("midrst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        idle(2, 1);
        send_frame(8'h81, 1'b0, 1'b0, 1);
        idle(3, 1);

        // Randomized frames, gaps, errors and consumer stalls
        for (int n = 0; n < 60; n++) begin
            logic [7:0] d;
            logic       bp, st;
            d  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 5) == 0);
            send_frame(d, bp, st, 2);
            if (st) begin
                int k = $urandom_range(0, 4);
                for (int i = 0; i < k; i++) step(1'b1, pick_rdy(2), 1'b0, '0, 1'b0, 1'b0);
                idle($urandom_range(1, 2), 2);
            end else begin
                idle($urandom_range(0, 2), 2);
            end
        end
        idle(4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
